// File: rtl/seq_dp_pkg.sv
// Shared types for the single-bus sequenced datapath: opcodes and sequencer states.
package seq_dp_pkg;

  localparam logic [2:0] OPC_LDI  = 3'd0;
  localparam logic [2:0] OPC_AND  = 3'd1;
  localparam logic [2:0] OPC_OR   = 3'd2;
  localparam logic [2:0] OPC_ADD  = 3'd3;
  localparam logic [2:0] OPC_SUB  = 3'd4;
  localparam logic [2:0] OPC_MUL  = 3'd5;
  localparam logic [2:0] OPC_MFHI = 3'd6;
  localparam logic [2:0] OPC_MFLO = 3'd7;

  typedef enum logic [2:0] {
    OP_LDI  = OPC_LDI,
    OP_AND  = OPC_AND,
    OP_OR   = OPC_OR,
    OP_ADD  = OPC_ADD,
    OP_SUB  = OPC_SUB,
    OP_MUL  = OPC_MUL,
    OP_MFHI = OPC_MFHI,
    OP_MFLO = OPC_MFLO
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    TY,
    TZ,
    MRUN,
    MWB,
    WB
  } state_t;

  // Ops that need no source operands go straight to write-back.
  function automatic logic is_direct(input op_t op);
    return (op == OP_LDI) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/seq_datapath_reg_bank.sv
// General register bank: one synchronous write port, two combinational read ports.
module reg_bank #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [RSEL_W-1:0] wsel,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [RSEL_W-1:0] asel,
  output logic [WIDTH-1:0]  adata,
  input  logic [RSEL_W-1:0] dsel,
  output logic [WIDTH-1:0]  ddata
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Selects at or beyond NREGS match no register, so such writes fall away.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!clr) begin
        mem_q[gi] <= '0;
      end else if (we && (32'(wsel) == gi)) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  assign adata = (32'(asel) < NREGS) ? mem_q[asel] : '0;
  assign ddata = (32'(dsel) < NREGS) ? mem_q[dsel] : '0;

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath with a built-in sequencer (Rb->Y, Rc->ALU->Z, Z->Ra)
// and an iterative shift-add multiplier writing {HI,LO}.
module seq_datapath
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [RSEL_W-1:0] cmd_ra,
  input  logic [RSEL_W-1:0] cmd_rb,
  input  logic [RSEL_W-1:0] cmd_rc,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              done,
  input  logic [RSEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  hi_q,
  output logic [WIDTH-1:0]  lo_q,
  output logic [WIDTH-1:0]  bus_q
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t            state_q, state_d;
  op_t               op_q;
  logic [RSEL_W-1:0] ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]  imm_q, y_q, zhi_q, zlo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [RSEL_W-1:0] bank_asel;
  logic [WIDTH-1:0]  bank_adata, alu_res, bus;
  logic [WIDTH:0]    step_sum;

  reg_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .RSEL_W(RSEL_W)) u_bank (
    .clk   (clk),
    .clr   (clr),
    .we    (state_q == WB),
    .wsel  (ra_q),
    .wdata (bus),
    .asel  (bank_asel),
    .adata (bank_adata),
    .dsel  (rd_sel),
    .ddata (rd_data)
  );

  assign bank_asel = (state_q == TZ) ? rc_q : rb_q;
  assign cmd_ready = (state_q == IDLE);
  assign bus_q     = bus;
  assign step_sum  = zlo_q[0] ? ({1'b0, zhi_q} + {1'b0, y_q}) : {1'b0, zhi_q};

  always_comb begin
    bus = '0;
    case (state_q)
      TY, TZ: bus = bank_adata;
      WB: begin
        case (op_q)
          OP_LDI:  bus = imm_q;
          OP_MFHI: bus = hi_q;
          OP_MFLO: bus = lo_q;
          default: bus = zlo_q;
        endcase
      end
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_AND:  alu_res = y_q & bus;
      OP_OR:   alu_res = y_q | bus;
      OP_ADD:  alu_res = y_q + bus;
      OP_SUB:  alu_res = y_q - bus;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = is_direct(op_t'(cmd_op)) ? WB : TY;
      TY:   state_d = TZ;
      TZ:   state_d = (op_q == OP_MUL) ? MRUN : WB;
      MRUN: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MWB;
      MWB:  state_d = IDLE;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= OP_LDI;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      imm_q   <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == WB) || (state_q == MWB);
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q  <= op_t'(cmd_op);
          ra_q  <= cmd_ra;
          rb_q  <= cmd_rb;
          rc_q  <= cmd_rc;
          imm_q <= cmd_imm;
        end
        TY: y_q <= bus;
        TZ: begin
          zhi_q <= '0;
          zlo_q <= (op_q == OP_MUL) ? bus : alu_res;
          cnt_q <= '0;
        end
        // Z_lo holds the unconsumed multiplier bits; product bits shift in from the top.
        MRUN: begin
          {zhi_q, zlo_q} <= {step_sum, zlo_q[WIDTH-1:1]};
          cnt_q          <= cnt_q + 1'b1;
        end
        MWB: begin
          hi_q <= zhi_q;
          lo_q <= zlo_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Randomised bench for seq_datapath against a command-level model of registers and HI/LO.
module tb_seq_datapath;

  localparam int W = 32;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [3:0]    cmd_ra = '0, cmd_rb = '0, cmd_rc = '0;
  logic [W-1:0]  cmd_imm = '0;
  logic          done;
  logic [3:0]    rd_sel = '0;
  logic [W-1:0]  rd_data, hi_q, lo_q, bus_q;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  seq_datapath #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
    .cmd_imm(cmd_imm), .done(done), .rd_sel(rd_sel), .rd_data(rd_data),
    .hi_q(hi_q), .lo_q(lo_q), .bus_q(bus_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Command-level model: results are computed at acceptance and committed
  // when the command's latency has elapsed.
  logic [W-1:0]   mregs [N];
  logic [W-1:0]   mhi = '0, mlo = '0;
  int             busy_left = 0;
  bit             done_exp = 1'b0;
  bit             p_mul;
  int             p_ra;
  logic [W-1:0]   p_val;
  logic [2*W-1:0] p_prod;

  always @(negedge clk) begin
    logic [W-1:0] a, b;
    if (chk_en) begin
      chk("ready", {63'b0, cmd_ready}, {63'b0, busy_left == 0});
      chk("done", {63'b0, done}, {63'b0, done_exp});
      chk("hi", {32'b0, hi_q}, {32'b0, mhi});
      chk("lo", {32'b0, lo_q}, {32'b0, mlo});
      chk("rd_data", {32'b0, rd_data}, {32'b0, mregs[rd_sel]});
      if (busy_left == 0) chk("bus_idle", {32'b0, bus_q}, 64'd0);
    end
    if (!clr) begin
      for (int i = 0; i < N; i++) mregs[i] = '0;
      mhi = '0; mlo = '0; busy_left = 0; done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          done_exp = 1'b1;
          if (p_mul) {mhi, mlo} = p_prod;
          else mregs[p_ra] = p_val;
        end
      end else if (cmd_valid) begin
        a = mregs[cmd_rb];
        b = mregs[cmd_rc];
        p_mul = 1'b0;
        p_ra = int'(cmd_ra);
        busy_left = 3;
        case (cmd_op)
          3'd0: begin p_val = cmd_imm; busy_left = 1; end
          3'd1: p_val = a & b;
          3'd2: p_val = a | b;
          3'd3: p_val = a + b;
          3'd4: p_val = a - b;
          3'd5: begin p_prod = {32'b0, a} * {32'b0, b}; p_mul = 1'b1; busy_left = W + 3; end
          3'd6: begin p_val = mhi; busy_left = 1; end
          default: begin p_val = mlo; busy_left = 1; end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    rd_sel = 4'($urandom_range(0, N - 1));
  endtask

  task automatic peek(input int s, input logic [W-1:0] exp, input string nm);
    tick();
    rd_sel = 4'(s);
    #1;
    chk(nm, {32'b0, rd_data}, {32'b0, exp});
  endtask

  task automatic issue(input logic [2:0] op, input int ra, input int rb, input int rc,
                       input logic [W-1:0] imm, input bit hold);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_ra = 4'(ra); cmd_rb = 4'(rb); cmd_rc = 4'(rc); cmd_imm = imm;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    if (g >= 100) chk("accept_timeout", {63'b0, cmd_ready}, 64'd1);
    $display("cmd op=%0d ra=%0d rb=%0d rc=%0d imm=%h t=%0t", op, ra, rb, rc, imm, $time);
    tick();
    cmd_valid = hold;
    cmd_op = 3'($urandom); cmd_ra = 4'($urandom); cmd_rb = 4'($urandom);
    cmd_rc = 4'($urandom); cmd_imm = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin tick(); n++; end while (!done && n < 200);
    if (!done) chk("done_timeout", {63'b0, done}, 64'd1);
  endtask

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd6 || op == 3'd7) return 1;
    if (op == 3'd5) return W + 3;
    return 3;
  endfunction

  initial begin
    int n;
    logic [2:0] op;
    clr = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    clr = 1'b1;
    chk("rst_ready", {63'b0, cmd_ready}, 64'd1);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi_q}, 64'd0);
    chk("rst_lo", {32'b0, lo_q}, 64'd0);
    chk("rst_bus", {32'b0, bus_q}, 64'd0);

    issue(3'd0, 3, 0, 0, 32'h0000_00F0, 1'b0); wait_done(n);
    chk("lat_ldi", 64'(n), 64'd1);
    peek(3, 32'h0000_00F0, "ldi_r3");
    for (int i = 0; i < N; i++) if (i != 3) peek(i, 32'h0, "ldi_others_zero");

    issue(3'd0, 1, 0, 0, 32'hFF00_FF00, 1'b0); wait_done(n);
    issue(3'd0, 2, 0, 0, 32'h0F0F_0F0F, 1'b0); wait_done(n);
    issue(3'd1, 4, 1, 2, 32'h0, 1'b0); wait_done(n);
    chk("lat_and", 64'(n), 64'd3);
    peek(4, 32'h0F00_0F00, "and_r4");
    issue(3'd3, 5, 1, 2, 32'h0, 1'b0); wait_done(n);
    peek(5, 32'h0E10_0E0F, "add_wrap_r5");

    issue(3'd4, 1, 1, 1, 32'h0, 1'b0); wait_done(n);
    peek(1, 32'h0, "sub_alias_r1");
    issue(3'd0, 0, 0, 0, 32'h0, 1'b0); wait_done(n);
    issue(3'd0, 6, 0, 0, 32'h1, 1'b0); wait_done(n);
    issue(3'd4, 2, 0, 6, 32'h0, 1'b0); wait_done(n);
    peek(2, 32'hFFFF_FFFF, "sub_neg_r2");

    issue(3'd0, 1, 0, 0, 32'hFFFF_FFFF, 1'b0); wait_done(n);
    issue(3'd0, 2, 0, 0, 32'h0000_0002, 1'b0); wait_done(n);
    issue(3'd5, 0, 1, 2, 32'h0, 1'b1); wait_done(n);
    cmd_valid = 1'b0;
    chk("lat_mul", 64'(n), 64'(W + 3));
    chk("mul_hi", {32'b0, hi_q}, 64'h1);
    chk("mul_lo", {32'b0, lo_q}, 64'hFFFF_FFFE);
    issue(3'd6, 7, 0, 0, 32'h0, 1'b0); wait_done(n);
    peek(7, 32'h1, "mfhi_r7");
    issue(3'd7, 8, 0, 0, 32'h0, 1'b0); wait_done(n);
    peek(8, 32'hFFFF_FFFE, "mflo_r8");

    // Accepted at edge k; MRUN step 10 is the cycle after edge k+12.
    issue(3'd5, 0, 1, 1, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    clr = 1'b0;
    tick();
    clr = 1'b1;
    chk("abort_ready", {63'b0, cmd_ready}, 64'd1);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hi", {32'b0, hi_q}, 64'd0);
    chk("abort_lo", {32'b0, lo_q}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort_no_done", {63'b0, done}, 64'd0);
    end
    peek(1, 32'h0, "abort_r1_clear");

    issue(3'd0, 9, 0, 0, 32'h1234_5678, 1'b0); wait_done(n);
    chk("b2b_lat_ldi", 64'(n), 64'd1);
    issue(3'd3, 10, 9, 9, 32'h0, 1'b0); wait_done(n);
    chk("b2b_lat_add", 64'(n), 64'd3);
    peek(10, 32'h2468_ACF0, "b2b_r10");

    for (int t = 0; t < 300; t++) begin
      int gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) tick();
      op = 3'($urandom);
      if ($urandom_range(0, 3) == 0) op = 3'd0;
      issue(op, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
            $urandom_range(0, N - 1), $urandom, 1'b0);
      if ($urandom_range(0, 39) == 0) begin
        int d = $urandom_range(0, 5);
        for (int i = 0; i < d; i++) tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
      end else begin
        wait_done(n);
        chk("rand_latency", 64'(n), 64'(lat_of(op)));
      end
    end

    for (int i = 0; i < N; i++) peek(i, mregs[i], "final_sweep");
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised successor to the single-bus CPU datapath. It holds a generic register bank plus HI/LO, Y and Z, all sharing one internal bus. An internal sequencer steps each command through the bus phases: Rb→Y, Rc→ALU→Z, then Z→Ra. It adds an iterative unsigned multiplier that writes {HI,LO}, and a valid/ready command handshake, so the block runs instructions without an external per-signal controller.

## Interface
Parameters:
- WIDTH, 32: datapath width, ≥2.
- NREGS, 16: general registers, 2..32. RSEL_W = $clog2(NREGS) is derived.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high exactly when the sequencer is IDLE.
- cmd_op  in  3  0 LDI, 1 AND, 2 OR, 3 ADD, 4 SUB, 5 MUL, 6 MFHI, 7 MFLO.
- cmd_ra  in  RSEL_W  destination register.
- cmd_rb  in  RSEL_W  first source register.
- cmd_rc  in  RSEL_W  second source register.
- cmd_imm  in  WIDTH  immediate value, used by LDI only.
- done  out  1  registered one-cycle pulse marking command completion.
- rd_sel  in  RSEL_W  debug read select.
- rd_data  out  WIDTH  combinational read of register rd_sel.
- hi_q  out  WIDTH  current HI value.
- lo_q  out  WIDTH  current LO value.
- bus_q  out  WIDTH  current internal bus value; 0 when no source drives it.

## Operation
Acceptance:
- A command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_* fields are captured into internal registers; external fields are ignored afterwards.
- cmd_valid is ignored while busy. Commands are never queued.

States and transitions:
- IDLE
  - LDI/MFHI/MFLO → WB.
  - AND/OR/ADD/SUB/MUL → TY.
- TY: bus = R[rb]; Y ← bus. Next is TZ.
- TZ: bus = R[rc].
  - ALU ops: Z_lo ← Y op bus; Z_hi ← 0; next is WB.
  - MUL: Z_lo ← bus (multiplier); Z_hi ← 0; cnt ← 0; next is MRUN.
- MRUN: one shift-add step per cycle.
  - If Z_lo[0], {c,s} = Z_hi + Y; otherwise {c,s} = {0,Z_hi}.
  - Then {Z_hi,Z_lo} ← {c,s,Z_lo[WIDTH-1:1]}.
  - After WIDTH steps, go to MWB.
- MWB: HI ← Z_hi; LO ← Z_lo; no general register is written. Next is IDLE.
- WB: R[ra] ← bus. Next is IDLE.
  - LDI: bus = cmd_imm (captured).
  - MFHI: bus = HI.
  - MFLO: bus = LO.
  - ALU ops: bus = Z_lo.
- done ← 1 on the edge leaving WB or MWB; otherwise done ← 0.

Arithmetic and data rules:
- ADD and SUB wrap modulo 2^WIDTH. No flags are produced.
- MUL is unsigned, WIDTH×WIDTH → 2·WIDTH. Y and Z keep their last values after a command.
- ra may equal rb and/or rc. Sources are read in earlier phases, so old values are always used.
- An index ≥ NREGS reads 0 and its writes are dropped.
- R0 is an ordinary register and is writable.

Reset:
- Applies when clr = 0 at an edge: all registers, HI, LO, Y and Z clear to 0; state goes to IDLE; done goes to 0.
- This holds mid-command: the command aborts, no done is emitted, and partial results are discarded.
- Reset values are cmd_ready=1, done=0, hi_q=0, lo_q=0, rd_data=0, bus_q=0.

## Timing
Latency, for a command accepted at edge k:
- LDI/MFHI/MFLO: result visible, and done high, after edge k+1.
- ALU ops: after edge k+3.
- MUL: after edge k+WIDTH+3.

Handshake and outputs:
- cmd_ready is high again in the same cycle that done is high. A new command can be accepted on that edge, so back-to-back issue is supported.
- rd_data is combinational from the bank. A write at edge e is visible on rd_data after e.
- bus_q is combinational from the state and captured indices.

## Structure
- Package seq_dp_pkg holds:
  - the op_t enum, 3 bits, with the encodings above;
  - the state_t enum: IDLE, TY, TZ, MRUN, MWB, WB;
  - the op-code localparams.
- Sub-module reg_bank, parametrised by WIDTH and NREGS:
  - one synchronous write port with active-low sync clear;
  - two combinational read ports, one for the bus and one for debug.
- The top level contains the sequencer, bus mux, Y/Z/HI/LO and the shift-add step.
- WIDTH=32 and WIDTH=8 must both elaborate.

## Test plan
- Reset then LDI: reset, then LDI R3 ← 0x0000_00F0. Expect done after 1 edge, rd_data(R3) = 0xF0, and all other registers 0.
- AND and ADD: R1 = 0xFF00_FF00, R2 = 0x0F0F_0F0F.
  - AND R4,R1,R2 gives R4 = 0x0F00_0F00, with done exactly 3 edges after acceptance.
  - ADD R5,R1,R2 gives 0x0E10_0E0F, showing wrap.
- Aliasing: SUB R1,R1,R1 gives R1 = 0. Then SUB R2,R0,R6 with R0 = 0 and R6 = 1 gives R2 = 0xFFFF_FFFF.
- MUL: R1 = 0xFFFF_FFFF, R2 = 0x0000_0002.
  - MUL R1,R2 leaves HI = 0x1 and LO = 0xFFFF_FFFE after WIDTH+3 edges.
  - MFHI R7 then gives R7 = 1.
  - cmd_valid held high throughout must not start a second command.
- Reset mid-MUL: pulse clr low during MRUN step 10. Expect no done pulse, HI = LO = 0, and cmd_ready = 1 on the next cycle.
- Back-to-back issue: LDI followed immediately by an ALU op in the done cycle. Both are accepted, and results match the latencies above.
